writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 9 +
 rtl/writeback_queue_wb_fifo.sv | 63 ++++++
 rtl/writeback_queue.sv | 78 +++++++
 tb/tb_writeback_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: shared CPU widths and the queued writeback entry type.
package writeback_queue_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_wb_fifo.sv
// wb_fifo: entry storage and pointers for the writeback queue; accepts up to two
// pushes per cycle (push0 older than push1) and one pop.
module wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push0,
  input  wb_entry_t              i_entry0,
  input  logic                   i_push1,
  input  wb_entry_t              i_entry1,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [CW-1:0]          o_count,
  output logic [PW-1:0]          o_head_ptr,
  output wb_entry_t [DEPTH-1:0]  o_mem,
  output logic [DEPTH-1:0]       o_vld
);
  wb_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  w_any;
  logic                  w_both;
  logic [PW-1:0]         w_tail1;
  wb_entry_t             w_first;
  assign w_any   = i_push0 | i_push1;
  assign w_both  = i_push0 & i_push1;
  assign w_tail1 = r_tail + PW'(1);
  assign w_first = i_push0 ? i_entry0 : i_entry1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_any) r_vld[r_tail] <= 1'b1;
      if (w_both) r_vld[w_tail1] <= 1'b1;
      r_tail  <= r_tail + PW'(w_any) + PW'(w_both);
      r_count <= r_count + CW'(w_any) + CW'(w_both) - CW'(i_pop);
    end
  end
  // Payload needs no reset: r_vld and r_count decide what is live.
  always_ff @(posedge clk) begin
    if (w_any) r_mem[r_tail] <= w_first;
    if (w_both) r_mem[w_tail1] <= i_entry1;
  end
  assign o_head     = r_mem[r_head];
  assign o_count    = r_count;
  assign o_head_ptr = r_head;
  assign o_mem      = r_mem;
  assign o_vld      = r_vld;
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: merges LSU and ALU results into an in-order register-file
// write stream, with pending/forward lookup for the decode-stage sources.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [REG_ADDR_W-1:0] i_lsu_rd,
  input  logic [XLEN-1:0]       i_lsu_data,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  output logic                  o_we,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_rd_data,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  output logic                  o_rs1_pending,
  output logic                  o_rs2_pending,
  output logic [XLEN-1:0]       o_rs1_fwd,
  output logic [XLEN-1:0]       o_rs2_fwd,
  output logic [CW-1:0]         o_count
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic [DEPTH-1:0]      w_vld;
  logic [PW-1:0]         w_head_ptr;
  logic [CW-1:0]         w_count;
  logic                  w_nonempty;
  logic                  w_lsu_go;
  logic                  w_alu_go;
  // Scans oldest to youngest so the last hit is the youngest matching entry.
  function automatic logic [XLEN:0] lookup(
    input logic [REG_ADDR_W-1:0] rs,
    input wb_entry_t [DEPTH-1:0] mem,
    input logic [DEPTH-1:0]      vld,
    input logic [PW-1:0]         head
  );
    lookup = '0;
    for (int k = 0; k < DEPTH; k++)
      if (rs != '0 && vld[head + PW'(k)] && mem[head + PW'(k)].rd == rs)
        lookup = {1'b1, mem[head + PW'(k)].data};
  endfunction
  assign o_lsu_ready = w_count < CW'(DEPTH);
  assign o_alu_ready = (w_count < CW'(DEPTH - 1)) | (o_lsu_ready & ~i_lsu_valid);
  assign w_lsu_go    = i_lsu_valid & o_lsu_ready;
  assign w_alu_go    = i_alu_valid & o_alu_ready;
  assign w_nonempty  = w_count != '0;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push0   (w_lsu_go & (i_lsu_rd != '0)),
    .i_entry0  ('{rd: i_lsu_rd, data: i_lsu_data}),
    .i_push1   (w_alu_go & (i_alu_rd != '0)),
    .i_entry1  ('{rd: i_alu_rd, data: i_alu_data}),
    .i_pop     (w_nonempty),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_head_ptr(w_head_ptr),
    .o_mem     (w_mem),
    .o_vld     (w_vld)
  );
  assign o_we      = w_nonempty;
  assign o_rd      = w_nonempty ? w_head.rd : '0;
  assign o_rd_data = w_nonempty ? w_head.data : '0;
  assign o_count   = w_count;
  always_comb begin
    {o_rs1_pending, o_rs1_fwd} = lookup(i_rs1, w_mem, w_vld, w_head_ptr);
    {o_rs2_pending, o_rs2_fwd} = lookup(i_rs2, w_mem, w_vld, w_head_ptr);
  end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus with a write-order scoreboard and a
// register-file model fed from the write port.
module tb_writeback_queue;
  import writeback_queue_pkg::*;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        i_lsu_valid = 0, i_alu_valid = 0;
  logic        o_lsu_ready, o_alu_ready;
  logic [4:0]  i_lsu_rd = 0, i_alu_rd = 0, i_rs1 = 0, i_rs2 = 0;
  logic [31:0] i_lsu_data = 0, i_alu_data = 0;
  logic        o_we, o_rs1_pending, o_rs2_pending;
  logic [4:0]  o_rd;
  logic [31:0] o_rd_data, o_rs1_fwd, o_rs2_fwd;
  logic [2:0]  o_count;
  int          total = 0;
  int          bad = 0;
  wb_entry_t   exp_q[$];
  wb_entry_t   mon_e;
  logic [31:0] rf [32] = '{default: '0};
  always #5 clk = ~clk;
  writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .o_we(o_we), .o_rd(o_rd), .o_rd_data(o_rd_data),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rs1_pending(o_rs1_pending), .o_rs2_pending(o_rs2_pending),
    .o_rs1_fwd(o_rs1_fwd), .o_rs2_fwd(o_rs2_fwd), .o_count(o_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic wb_entry_t mk(input logic [4:0] rd, input logic [31:0] data);
    mk.rd = rd;
    mk.data = data;
  endfunction
  always @(posedge clk) if (rst_n && o_we) rf[o_rd] <= o_rd_data;
  always @(negedge clk) begin
    if (rst_n && o_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no write", o_rd, o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_rd", 32'(o_rd), 32'(mon_e.rd));
        check("wb_data", o_rd_data, mon_e.data);
      end
    end
  end
  task automatic xfer(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad);
    logic lp, ap, lr, ar;
    lp = lv;
    ap = av;
    @(posedge clk); #1;
    i_lsu_valid = lp; i_lsu_rd = lrd; i_lsu_data = ld;
    i_alu_valid = ap; i_alu_rd = ard; i_alu_data = ad;
    for (int n = 0; n < 20 && (lp || ap); n++) begin
      @(negedge clk);
      lr = o_lsu_ready;
      ar = o_alu_ready;
      @(posedge clk);
      if (lp && lr) begin
        if (lrd != 0) exp_q.push_back(mk(lrd, ld));
        lp = 0;
      end
      if (ap && ar) begin
        if (ard != 0) exp_q.push_back(mk(ard, ad));
        ap = 0;
      end
      #1;
      i_lsu_valid = lp;
      i_alu_valid = ap;
    end
    if (lp || ap) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got pending lsu=%0b alu=%0b expected accepted", lp, ap);
      i_lsu_valid = 0;
      i_alu_valid = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ar_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   cnt_exp [5] = '{0, 2, 3, 3, 3};
    int   a;
    repeat (2) @(negedge clk);
    i_rs1 = 3;
    check("rst_count", 32'(o_count), 0);
    check("rst_we", 32'(o_we), 0);
    check("rst_rd", 32'(o_rd), 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_lsu_ready", 32'(o_lsu_ready), 1);
    check("rst_alu_ready", 32'(o_alu_ready), 1);
    check("rst_pending", 32'(o_rs1_pending), 0);
    @(posedge clk); #1 rst_n = 1;
    // single push
    xfer(1, 3, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk);
    check("single_we", 32'(o_we), 1);
    check("single_rd", 32'(o_rd), 3);
    check("single_data", o_rd_data, 32'hDEADBEEF);
    check("single_pending", 32'(o_rs1_pending), 1);
    check("single_fwd", o_rs1_fwd, 32'hDEADBEEF);
    check("single_count", 32'(o_count), 1);
    @(posedge clk); #1;
    check("single_rf_x3", rf[3], 32'hDEADBEEF);
    @(negedge clk);
    check("single_empty_count", 32'(o_count), 0);
    check("single_empty_we", 32'(o_we), 0);
    // dual push to the same register
    i_rs2 = 5;
    xfer(1, 5, 32'h11, 1, 5, 32'h22);
    @(negedge clk);
    check("dual_count", 32'(o_count), 2);
    check("dual_pending", 32'(o_rs2_pending), 1);
    check("dual_fwd_youngest", o_rs2_fwd, 32'h22);
    check("dual_head_data", o_rd_data, 32'h11);
    repeat (2) @(posedge clk); #1;
    check("dual_rf_x5", rf[5], 32'h22);
    check("dual_count_end", 32'(o_count), 0);
    // write to x0 is accepted and dropped
    i_rs1 = 0;
    @(posedge clk); #1;
    i_alu_valid = 1; i_alu_rd = 0; i_alu_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("x0_alu_ready", 32'(o_alu_ready), 1);
    @(posedge clk); #1 i_alu_valid = 0;
    @(negedge clk);
    check("x0_count", 32'(o_count), 0);
    check("x0_we", 32'(o_we), 0);
    check("x0_pending", 32'(o_rs1_pending), 0);
    // fill with both sources held valid
    a = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      i_lsu_valid = 1; i_lsu_rd = 5'(8 + c); i_lsu_data = 32'h100 + 32'(c);
      i_alu_valid = 1; i_alu_rd = 5'(16 + a); i_alu_data = 32'h200 + 32'(a);
      @(negedge clk);
      check($sformatf("full_count_%0d", c), 32'(o_count), 32'(cnt_exp[c]));
      check($sformatf("full_lsu_ready_%0d", c), 32'(o_lsu_ready), 1);
      check($sformatf("full_alu_ready_%0d", c), 32'(o_alu_ready), 32'(ar_exp[c]));
      @(posedge clk);
      exp_q.push_back(mk(i_lsu_rd, i_lsu_data));
      if (ar_exp[c]) begin
        exp_q.push_back(mk(i_alu_rd, i_alu_data));
        a++;
      end
      #1;
    end
    i_lsu_valid = 0;
    i_alu_rd = 5'(16 + a); i_alu_data = 32'h200 + 32'(a);
    @(negedge clk);
    check("full_alu_only_count", 32'(o_count), 3);
    check("full_alu_only_ready", 32'(o_alu_ready), 1);
    @(posedge clk);
    exp_q.push_back(mk(i_alu_rd, i_alu_data));
    #1 i_alu_valid = 0;
    repeat (4) @(posedge clk); #1;
    check("full_drained_count", 32'(o_count), 0);
    check("full_drained_queue", 32'(exp_q.size()), 0);
    // pointer wrap over many sequential pushes
    for (int i = 1; i <= 10; i++) xfer(1, 5'(i), 32'(i) * 32'h100, 0, 0, 0);
    repeat (3) @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) check($sformatf("wrap_rf_x%0d", i), rf[i], 32'(i) * 32'h100);
    check("wrap_count", 32'(o_count), 0);
    // asynchronous reset with entries in flight
    i_rs1 = 23;
    @(posedge clk); #1;
    i_lsu_valid = 1; i_lsu_rd = 20; i_lsu_data = 32'hA20;
    i_alu_valid = 1; i_alu_rd = 21; i_alu_data = 32'hA21;
    @(posedge clk);
    exp_q.push_back(mk(20, 32'hA20));
    exp_q.push_back(mk(21, 32'hA21));
    #1;
    i_lsu_rd = 22; i_lsu_data = 32'hA22;
    i_alu_rd = 23; i_alu_data = 32'hA23;
    @(posedge clk);
    exp_q.push_back(mk(22, 32'hA22));
    exp_q.push_back(mk(23, 32'hA23));
    #1;
    i_lsu_valid = 0; i_alu_valid = 0;
    check("rst_mid_count_before", 32'(o_count), 3);
    check("rst_mid_fwd_before", o_rs1_fwd, 32'hA23);
    #1 rst_n = 0;
    #1;
    check("rst_mid_we", 32'(o_we), 0);
    check("rst_mid_count", 32'(o_count), 0);
    check("rst_mid_rd_data", o_rd_data, 0);
    check("rst_mid_pending", 32'(o_rs1_pending), 0);
    check("rst_mid_fwd", o_rs1_fwd, 0);
    check("rst_mid_lsu_ready", 32'(o_lsu_ready), 1);
    check("rst_mid_alu_ready", 32'(o_alu_ready), 1);
    exp_q.delete();
    #1 rst_n = 1;
    xfer(1, 7, 32'h77, 0, 0, 0);
    repeat (3) @(posedge clk); #1;
    check("post_rst_rf_x7", rf[7], 32'h77);
    check("post_rst_count", 32'(o_count), 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
